// File: rtl/frame_buf_sched_pkg.sv
// frame_buf_sched_pkg: channel FSM encoding, buffer count and triple-buffer index rotation
// shared by the frame buffer scheduler and its line channels.
package frame_buf_sched_pkg;
    localparam logic [1:0] NUM_BUF = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_BUSY, ST_NEXT} chan_state_t;
    function automatic logic [1:0] buf_rot(input logic [1:0] idx, input logic [1:0] step);
        logic [2:0] s;
        s = {1'b0, idx} + {1'b0, step};
        return (s >= {1'b0, NUM_BUF}) ? 2'(s - {1'b0, NUM_BUF}) : s[1:0];
    endfunction
endpackage

// File: rtl/fbs_line_chan.sv
// fbs_line_chan: one command channel (write or read): pending line requests, IDLE/CMD/BUSY/NEXT
// sequencing of the burst master, line counter and line address accumulator.
module fbs_line_chan
    import frame_buf_sched_pkg::*;
#(
    parameter logic [31:0] LINE_BYTES = 32'd5120,
    parameter int          V_LINES    = 720,
    parameter int          PEND_W     = 4,
    parameter logic [31:0] RST_ADRS   = 32'h1000_0000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        i_soft_rst,
    input  logic        i_line_req,
    input  logic        i_frame_start,
    input  logic [31:0] i_frame_base,
    input  logic        i_ready,
    input  logic        i_done,
    output logic        o_start,
    output logic [31:0] o_adrs,
    output logic        o_apply,
    output logic        o_drop,
    output logic        o_frame_done
);
    localparam int              LW   = $clog2(V_LINES + 1);
    localparam logic [LW-1:0]   LAST = LW'(V_LINES);
    localparam logic [PEND_W-1:0] PMAX = '1;

    chan_state_t       r_state, w_state_nx;
    logic [PEND_W-1:0] r_pend;
    logic [LW-1:0]     r_line;
    logic [31:0]       r_adrs;
    logic              r_frame_pend;
    logic              w_line_ok, w_dec, w_inc;

    assign w_line_ok    = r_line < LAST;
    assign w_dec        = r_state == ST_CMD;
    // Frame starts only take effect between bursts; a same-cycle line request joins the new frame.
    assign o_apply      = (r_frame_pend || i_frame_start) && r_state == ST_IDLE && !i_soft_rst;
    assign o_drop       = i_line_req && !o_apply && !i_soft_rst &&
                          (!w_line_ok || (r_pend == PMAX && !w_dec));
    assign w_inc        = i_line_req && !o_drop;
    assign o_start      = r_state == ST_CMD;
    assign o_adrs       = r_adrs;
    assign o_frame_done = r_state == ST_NEXT && r_line == LAST - 1'b1;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (!o_apply && r_pend != '0 && i_ready && w_line_ok) w_state_nx = ST_CMD;
            ST_CMD:  w_state_nx = ST_BUSY;
            ST_BUSY: if (i_done) w_state_nx = ST_NEXT;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= ST_IDLE;
        else          r_state <= i_soft_rst ? ST_IDLE : w_state_nx;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pend       <= '0;
            r_line       <= '0;
            r_adrs       <= RST_ADRS;
            r_frame_pend <= 1'b0;
        end else if (i_soft_rst) begin
            r_pend       <= '0;
            r_frame_pend <= 1'b0;
        end else if (o_apply) begin
            r_pend       <= PEND_W'(i_line_req);
            r_line       <= '0;
            r_adrs       <= i_frame_base;
            r_frame_pend <= 1'b0;
        end else begin
            r_frame_pend <= r_frame_pend || i_frame_start;
            r_pend       <= r_pend + PEND_W'(w_inc) - PEND_W'(w_dec);
            if (r_state == ST_NEXT) begin
                r_line <= r_line + 1'b1;
                r_adrs <= r_adrs + LINE_BYTES;
            end
        end
    end
endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffered DDR frame store scheduler feeding the burst master's write/read channels.
// Defining FRAME_BUF_SCHED_STATS_EN adds frame/drop statistics counters.
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'h0040_0000,
    parameter logic [31:0] LINE_BYTES  = 32'd5120,
    parameter int          V_LINES     = 720,
    parameter int          PEND_W      = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        soft_rst,
    input  logic        wr_frame_start,
    input  logic        wr_line_req,
    input  logic        rd_frame_start,
    input  logic        rd_line_req,
    output logic        MASTER_RST,
    output logic        WR_START,
    output logic [31:0] WR_ADRS,
    output logic [31:0] WR_LEN,
    input  logic        WR_READY,
    input  logic        WR_DONE,
    output logic        RD_START,
    output logic [31:0] RD_ADRS,
    output logic [31:0] RD_LEN,
    input  logic        RD_READY,
    input  logic        RD_DONE,
    output logic [1:0]  wr_idx,
    output logic [1:0]  rd_idx,
    output logic        err_drop
`ifdef FRAME_BUF_SCHED_STATS_EN
    ,
    output logic [15:0] stat_wr_frames,
    output logic [15:0] stat_rd_frames,
    output logic [15:0] stat_drops
`endif
);
    localparam logic [31:0] BASE1 = BASE_ADDR + FRAME_BYTES;
    localparam logic [31:0] BASE2 = BASE1 + FRAME_BYTES;

    logic [1:0] r_wr_idx, r_rd_idx, r_last_done;
    logic       r_master_rst, r_err_drop, r_wr_complete;
    logic       w_wr_apply, w_rd_apply, w_wr_drop, w_rd_drop, w_wr_frame_done;
    logic [1:0] w_rd_tgt, w_rd_new, w_wr_step, w_wr_tgt;

    function automatic logic [31:0] frame_base(input logic [1:0] idx);
        return (idx == 2'd0) ? BASE_ADDR : (idx == 2'd1) ? BASE1 : BASE2;
    endfunction

    // A completed frame may be read while wr_idx still names it; the writer leaves it on its next frame start.
    assign w_rd_tgt  = (r_last_done == r_wr_idx && !r_wr_complete) ? r_rd_idx : r_last_done;
    assign w_rd_new  = w_rd_apply ? w_rd_tgt : r_rd_idx;
    assign w_wr_step = buf_rot(r_wr_idx, 2'd1);
    assign w_wr_tgt  = (w_wr_step == w_rd_new) ? buf_rot(r_wr_idx, 2'd2) : w_wr_step;

    fbs_line_chan #(
        .LINE_BYTES(LINE_BYTES), .V_LINES(V_LINES), .PEND_W(PEND_W), .RST_ADRS(BASE_ADDR)
    ) u_wr (
        .ACLK(ACLK), .ARESETN(ARESETN), .i_soft_rst(soft_rst), .i_line_req(wr_line_req),
        .i_frame_start(wr_frame_start), .i_frame_base(frame_base(w_wr_tgt)),
        .i_ready(WR_READY), .i_done(WR_DONE), .o_start(WR_START), .o_adrs(WR_ADRS),
        .o_apply(w_wr_apply), .o_drop(w_wr_drop), .o_frame_done(w_wr_frame_done)
    );

    fbs_line_chan #(
        .LINE_BYTES(LINE_BYTES), .V_LINES(V_LINES), .PEND_W(PEND_W), .RST_ADRS(BASE2)
    ) u_rd (
        .ACLK(ACLK), .ARESETN(ARESETN), .i_soft_rst(soft_rst), .i_line_req(rd_line_req),
        .i_frame_start(rd_frame_start), .i_frame_base(frame_base(w_rd_tgt)),
        .i_ready(RD_READY), .i_done(RD_DONE), .o_start(RD_START), .o_adrs(RD_ADRS),
        .o_apply(w_rd_apply), .o_drop(w_rd_drop), .o_frame_done()
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_idx      <= 2'd0;
            r_rd_idx      <= 2'd2;
            r_last_done   <= 2'd2;
            r_master_rst  <= 1'b0;
            r_err_drop    <= 1'b0;
            r_wr_complete <= 1'b0;
        end else begin
            r_master_rst  <= soft_rst;
            r_err_drop    <= r_err_drop || w_wr_drop || w_rd_drop;
            r_wr_complete <= w_wr_frame_done || (r_wr_complete && !w_wr_apply);
            if (w_wr_apply) r_wr_idx <= w_wr_tgt;
            if (w_rd_apply) r_rd_idx <= w_rd_tgt;
            if (w_wr_frame_done) r_last_done <= r_wr_idx;
        end
    end

    assign MASTER_RST = r_master_rst;
    assign WR_LEN     = LINE_BYTES;
    assign RD_LEN     = LINE_BYTES;
    assign wr_idx     = r_wr_idx;
    assign rd_idx     = r_rd_idx;
    assign err_drop   = r_err_drop;

`ifdef FRAME_BUF_SCHED_STATS_EN
    logic [15:0] r_stat_wr, r_stat_rd, r_stat_drop;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_stat_wr   <= '0;
            r_stat_rd   <= '0;
            r_stat_drop <= '0;
        end else begin
            r_stat_wr   <= r_stat_wr + 16'(w_wr_frame_done);
            r_stat_rd   <= r_stat_rd + 16'(w_rd_apply);
            r_stat_drop <= r_stat_drop + 16'(w_wr_drop) + 16'(w_rd_drop);
        end
    end

    assign stat_wr_frames = r_stat_wr;
    assign stat_rd_frames = r_stat_rd;
    assign stat_drops     = r_stat_drop;
`endif
endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: scoreboard bench for frame_buf_sched with simple write/read master models.
module tb_frame_buf_sched;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] FB   = 32'h0040_0000;
    localparam logic [31:0] LB   = 32'd5120;

    logic ACLK = 1'b0;
    logic ARESETN, soft_rst, wr_frame_start, wr_line_req, rd_frame_start, rd_line_req;
    logic MASTER_RST, WR_START, WR_READY, WR_DONE, RD_START, RD_READY, RD_DONE, err_drop;
    logic [31:0] WR_ADRS, WR_LEN, RD_ADRS, RD_LEN;
    logic [1:0]  wr_idx, rd_idx;
`ifdef FRAME_BUF_SCHED_STATS_EN
    logic [15:0] stat_wr_frames, stat_rd_frames, stat_drops;
`endif

    int n_cmp = 0, n_bad = 0;
    int n_ws = 0, n_wd = 0, n_rs = 0, n_rd = 0;
    int wr_lat = 5, rd_lat = 2;
    bit wr_busy = 0, rd_busy = 0, wr_skip = 0, rd_skip = 0;
    logic [31:0] wr_q[$], rd_q[$];
    logic [31:0] wbase, rbase;
    int wline = 0, rline = 0;

    frame_buf_sched dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .soft_rst(soft_rst),
        .wr_frame_start(wr_frame_start), .wr_line_req(wr_line_req),
        .rd_frame_start(rd_frame_start), .rd_line_req(rd_line_req),
        .MASTER_RST(MASTER_RST), .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_LEN(WR_LEN),
        .WR_READY(WR_READY), .WR_DONE(WR_DONE), .RD_START(RD_START), .RD_ADRS(RD_ADRS),
        .RD_LEN(RD_LEN), .RD_READY(RD_READY), .RD_DONE(RD_DONE),
        .wr_idx(wr_idx), .rd_idx(rd_idx), .err_drop(err_drop)
`ifdef FRAME_BUF_SCHED_STATS_EN
        , .stat_wr_frames(stat_wr_frames), .stat_rd_frames(stat_rd_frames), .stat_drops(stat_drops)
`endif
    );

    initial forever #5 ACLK = ~ACLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fbase(input int i);
        return BASE + FB * 32'(i);
    endfunction

    // Scoreboard: every START pops the oldest expected line address.
    initial forever begin
        @(negedge ACLK);
        if (WR_START === 1'b1) begin
            n_ws++;
            check("wr_start_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) check("wr_adrs", WR_ADRS, wr_q.pop_front());
        end
        if (RD_START === 1'b1) begin
            n_rs++;
            check("rd_start_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check("rd_adrs", RD_ADRS, rd_q.pop_front());
        end
    end

    initial begin
        logic [31:0] a;
        WR_DONE = 1'b0;
        forever begin
            @(negedge ACLK);
            if (WR_START === 1'b1) begin
                wr_busy = 1; a = WR_ADRS;
                repeat (wr_lat - 1) @(negedge ACLK);
                if (!wr_skip) check("wr_hold", WR_ADRS, a);
                WR_DONE = 1'b1;
                @(negedge ACLK);
                WR_DONE = 1'b0; wr_busy = 0; n_wd++;
            end
        end
    end

    initial begin
        logic [31:0] a;
        RD_DONE = 1'b0;
        forever begin
            @(negedge ACLK);
            if (RD_START === 1'b1) begin
                rd_busy = 1; a = RD_ADRS;
                repeat (rd_lat - 1) @(negedge ACLK);
                if (!rd_skip) check("rd_hold", RD_ADRS, a);
                RD_DONE = 1'b1;
                @(negedge ACLK);
                RD_DONE = 1'b0; rd_busy = 0; n_rd++;
            end
        end
    end

    task automatic drain();
        int t = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0 || n_ws != n_wd || n_rs != n_rd) && t < 400) begin
            @(negedge ACLK);
            t++;
        end
        check("drain_timeout", 32'(t < 400), 32'd1);
        repeat (3) @(negedge ACLK);
    endtask

    task automatic wr_line(input bit accept);
        @(negedge ACLK);
        wr_line_req = 1'b1;
        if (accept) begin wr_q.push_back(wbase + LB * 32'(wline)); wline++; end
        @(negedge ACLK);
        wr_line_req = 1'b0;
    endtask

    task automatic rd_line();
        @(negedge ACLK);
        rd_line_req = 1'b1;
        rd_q.push_back(rbase + LB * 32'(rline)); rline++;
        @(negedge ACLK);
        rd_line_req = 1'b0;
    endtask

    task automatic wr_fs();
        @(negedge ACLK); wr_frame_start = 1'b1;
        @(negedge ACLK); wr_frame_start = 1'b0;
    endtask

    task automatic rd_fs();
        @(negedge ACLK); rd_frame_start = 1'b1;
        @(negedge ACLK); rd_frame_start = 1'b0;
    endtask

    initial begin
        int s, t;
        ARESETN = 1'b0; soft_rst = 1'b0;
        wr_frame_start = 1'b0; wr_line_req = 1'b0; rd_frame_start = 1'b0; rd_line_req = 1'b0;
        WR_READY = 1'b1; RD_READY = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_wr_start", WR_START, 0);
        check("rst_rd_start", RD_START, 0);
        check("rst_master_rst", MASTER_RST, 0);
        check("rst_err_drop", err_drop, 0);
        check("rst_wr_idx", wr_idx, 0);
        check("rst_rd_idx", rd_idx, 2);
        check("rst_wr_adrs", WR_ADRS, 32'h1000_0000);
        check("rst_rd_adrs", RD_ADRS, 32'h1080_0000);
        check("rst_wr_len", WR_LEN, 32'd5120);
        check("rst_rd_len", RD_LEN, 32'd5120);
        ARESETN = 1'b1;
        @(negedge ACLK);

        wr_fs();
        check("fs1_wr_idx", wr_idx, 1);
        check("fs1_wr_adrs", WR_ADRS, 32'h1040_0000);
        wbase = fbase(1); wline = 0;
        @(negedge ACLK);
        wr_line_req = 1'b1;
        wr_q.push_back(wbase); wline++;
        @(negedge ACLK);
        wr_line_req = 1'b0;
        check("lat_cycle1", WR_START, 0);
        @(negedge ACLK);
        check("lat_cycle2", WR_START, 1);
        wr_line(1); wr_line(1);
        drain();
        check("three_lines_count", n_ws, 3);
        check("three_lines_wr_idx", wr_idx, 1);
        check("no_drop_yet", err_drop, 0);

        wr_lat = 2; WR_READY = 1'b0; s = n_ws;
        @(negedge ACLK);
        wr_line_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < 15) begin wr_q.push_back(wbase + LB * 32'(wline)); wline++; end
            @(negedge ACLK);
        end
        wr_line_req = 1'b0;
        check("ovf_err_drop", err_drop, 1);
        check("ovf_no_start_busy", n_ws - s, 0);
        WR_READY = 1'b1;
        drain();
        check("ovf_issued", n_ws - s, 15);

        while (wline < 720) begin wr_line(1); drain(); end
        s = n_ws;
        wr_line(0);
        drain();
        check("past_frame_dropped", n_ws - s, 0);

        rd_fs();
        check("rd_fs_rd_idx", rd_idx, 1);
        check("rd_fs_rd_adrs", RD_ADRS, 32'h1040_0000);
        rbase = fbase(1); rline = 0;
        rd_line(); rd_line();
        drain();

        wr_fs();
        check("rot_a", wr_idx, 2);
        wr_fs();
        check("rot_b", wr_idx, 0);
        wr_fs();
        check("rot_skip_rd", wr_idx, 2);
        check("rot_skip_adrs", WR_ADRS, fbase(2));
        wbase = fbase(2); wline = 0;

        wr_lat = 8;
        wr_line(1);
        t = 0;
        while (!wr_busy && t < 20) begin @(negedge ACLK); t++; end
        check("busy_wait", 32'(t < 20), 1);
        wr_fs();
        check("busy_fs_idx_held", wr_idx, 2);
        check("busy_fs_adrs_held", WR_ADRS, fbase(2));
        drain();
        check("busy_fs_idx_after", wr_idx, 0);
        check("busy_fs_adrs_after", WR_ADRS, fbase(0));
        wbase = fbase(0); wline = 0;

        rd_lat = 20;
        rd_line();
        t = 0;
        while (!rd_busy && t < 20) begin @(negedge ACLK); t++; end
        check("rd_busy_wait", 32'(t < 20), 1);
        rd_skip = 1;
        @(negedge ACLK); soft_rst = 1'b1;
        @(negedge ACLK); soft_rst = 1'b0;
        check("srst_master_rst_hi", MASTER_RST, 1);
        @(negedge ACLK);
        check("srst_master_rst_lo", MASTER_RST, 0);
        check("srst_rd_idx_kept", rd_idx, 1);
        check("srst_wr_idx_kept", wr_idx, 0);
        rd_fs();
        check("srst_rd_fsm_idle", RD_ADRS, fbase(1));
        rbase = fbase(1); rline = 0;
        s = n_rs; t = 0;
        while (n_rd != n_rs && t < 60) begin @(negedge ACLK); t++; end
        check("srst_done_wait", 32'(t < 60), 1);
        repeat (5) @(negedge ACLK);
        rd_skip = 0;
        check("srst_done_ignored", RD_ADRS, fbase(1));
        check("srst_no_start", n_rs - s, 0);
        rd_line();
        drain();

        wr_line(1);
        t = 0;
        while (!wr_busy && t < 20) begin @(negedge ACLK); t++; end
        check("arst_busy_wait", 32'(t < 20), 1);
        wr_skip = 1;
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        check("arst_wr_idx", wr_idx, 0);
        check("arst_rd_idx", rd_idx, 2);
        check("arst_wr_adrs", WR_ADRS, 32'h1000_0000);
        check("arst_rd_adrs", RD_ADRS, 32'h1080_0000);
        check("arst_err_drop", err_drop, 0);
        check("arst_wr_start", WR_START, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        drain();
        wr_skip = 0;

        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
